// File: rtl/residual_decompress.sv
// rtl/residual_decompress.sv - residual block decoder: header + packed bitstream to 32 RGBA pixels
module residual_decompress #(
  parameter int NUM_PIXELS = 32,
  parameter int IN_W       = 64,
  parameter int BUF_W      = 128
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_hdr_valid,
  output logic                       o_hdr_ready,
  input  logic [31:0]                i_hdr_min,
  input  logic [15:0]                i_hdr_width,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [IN_W-1:0]            i_in_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [NUM_PIXELS*32-1:0]   o_out_pixels
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_OUT} state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [31:0]               r_min;
  logic [15:0]               r_wid;
  logic [5:0]                r_pix_bits;
  logic [4:0]                r_words_left;
  logic [BUF_W-1:0]          r_buf;
  logic [7:0]                r_count;
  logic [5:0]                r_pix_idx;
  logic [NUM_PIXELS*32-1:0]  r_pixels;

  logic [15:0]               w_sat;
  logic [5:0]                w_hdr_bits;
  logic [4:0]                w_hdr_words;
  logic                      w_in_ready;
  logic                      w_acc;
  logic                      w_ext;
  logic                      w_last_ext;
  logic [7:0]                w_ext_bits;
  logic [7:0]                w_append_pos;
  logic [BUF_W-1:0]          w_buf_next;
  logic [7:0]                w_count_next;
  logic [31:0]               w_pixel;
  logic [5:0]                w_off;
  logic [7:0]                w_res;

  function automatic logic [7:0] f_mask(input logic [3:0] w);
    logic [8:0] m;
    m = (9'd1 << w) - 9'd1;
    return m[7:0];
  endfunction

  // Saturate header widths to 8 and derive bits per pixel and words per block
  always_comb begin
    w_sat = '0;
    for (int c = 0; c < 4; c++) begin
      w_sat[4*c +: 4] = (i_hdr_width[4*c +: 4] > 4'd8) ? 4'd8 : i_hdr_width[4*c +: 4];
    end
    w_hdr_bits  = {2'b0, w_sat[3:0]} + {2'b0, w_sat[7:4]} + {2'b0, w_sat[11:8]} + {2'b0, w_sat[15:12]};
    w_hdr_words = 5'((w_hdr_bits + 6'd1) >> 1);
  end

  assign w_in_ready = (r_state == S_DECODE) && (r_count <= 8'(BUF_W - IN_W)) && (r_words_left != 5'd0);
  assign w_acc      = w_in_ready && i_in_valid;
  assign w_ext      = (r_state == S_DECODE) && (r_count >= {2'b0, r_pix_bits}) &&
                      (r_pix_idx < 6'(NUM_PIXELS));
  assign w_last_ext = w_ext && (r_pix_idx == 6'(NUM_PIXELS - 1));
  assign w_ext_bits = w_ext ? {2'b0, r_pix_bits} : 8'd0;

  // Buffer keeps bits above count zero, so the new word can simply be OR-ed in after the shift
  always_comb begin
    w_append_pos = r_count - w_ext_bits;
    w_buf_next   = r_buf >> w_ext_bits;
    if (w_acc) begin
      w_buf_next = w_buf_next | ({{(BUF_W-IN_W){1'b0}}, i_in_data} << w_append_pos);
    end
    w_count_next = r_count - w_ext_bits + (w_acc ? 8'(IN_W) : 8'd0);
  end

  // Split the low pix_bits of the buffer into r,g,b,a residuals and add the minimums back
  always_comb begin
    w_pixel = '0;
    w_off   = '0;
    w_res   = '0;
    for (int c = 0; c < 4; c++) begin
      w_res   = 8'(r_buf >> w_off) & f_mask(r_wid[4*c +: 4]);
      w_pixel[8*c +: 8] = r_min[8*c +: 8] + w_res;
      w_off   = w_off + {2'b0, r_wid[4*c +: 4]};
    end
  end

  // Next-state selection
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_hdr_valid) w_state_next = S_DECODE;
      S_DECODE: if (w_last_ext)  w_state_next = S_OUT;
      S_OUT:    if (i_out_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Header latch, bit buffer, word/pixel counters and the output pixel store
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_min        <= '0;
      r_wid        <= '0;
      r_pix_bits   <= '0;
      r_words_left <= '0;
      r_buf        <= '0;
      r_count      <= '0;
      r_pix_idx    <= '0;
      r_pixels     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_hdr_valid) begin
            r_min        <= i_hdr_min;
            r_wid        <= w_sat;
            r_pix_bits   <= w_hdr_bits;
            r_words_left <= w_hdr_words;
            r_buf        <= '0;
            r_count      <= '0;
            r_pix_idx    <= '0;
          end
        end
        S_DECODE: begin
          if (w_last_ext) begin
            r_buf   <= '0;
            r_count <= '0;
          end else begin
            r_buf   <= w_buf_next;
            r_count <= w_count_next;
          end
          if (w_acc) r_words_left <= r_words_left - 5'd1;
          if (w_ext) begin
            r_pixels[{r_pix_idx[4:0], 5'b0} +: 32] <= w_pixel;
            r_pix_idx <= r_pix_idx + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hdr_ready  = (r_state == S_IDLE);
  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = (r_state == S_OUT);
  assign o_out_pixels = r_pixels;

endmodule

// File: doc/residual_decompress.md
# residual_decompress

Decompression-side counterpart of the residual compression stage. Accepts a block header (per-channel minimums and residual bit widths) plus a packed, LSB-first residual bitstream. Unpacks one pixel per cycle, adds the channel minimums back with 8-bit wrap, and presents the reconstructed 32-pixel RGBA block on a valid/ready output. Sits between the compressed-stream receive buffer and the pixel writeback path.

## Interface
- NUM_PIXELS, 32, pixels per block.
- IN_W, 64, input word width in bits; fixed at 64 for this revision.
- BUF_W, 128, bit-buffer width; must equal 2*IN_W.

- clk  in  1  clock; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- hdr_valid  in  1  header offered.
- hdr_ready  out  1  header accepted; high only in IDLE.
- hdr_min  in  32  channel minimums {a_min,b_min,g_min,r_min}, 8 bits each.
- hdr_width  in  16  residual widths {w_a,w_b,w_g,w_r}, 4 bits each; width 0 = channel skipped.
- in_valid  in  1  stream word offered.
- in_ready  out  1  stream word accepted.
- in_data  in  IN_W  packed residual bits, bit 0 first.
- out_valid  out  1  reconstructed block available.
- out_ready  in  1  downstream accepts the block.
- out_pixels  out  NUM_PIXELS*32  pixel i occupies [32i+31:32i] as {a,b,g,r}, with r in the low byte.

## Operation
- Width legalisation: any hdr_width field greater than 8 is saturated to 8 when the header is latched. All later counts use the saturated widths.
- Latched values: pix_bits = w_r+w_g+w_b+w_a (0..32) and words_left = ceil(pix_bits*NUM_PIXELS/IN_W) = ceil(pix_bits/2).
- Stream format:
  - Pixels are packed in order 0..31.
  - Within a pixel, channels are packed r, g, b, a; each channel uses w_c bits, LSB first.
  - Unused bits in the final word are discarded.
  - Every block starts on a fresh word.
- States:
  - IDLE: hdr_ready=1. On hdr_valid, latch min, widths, pix_bits and words_left; clear the buffer, the bit count and pix_idx; go to DECODE.
  - DECODE:
    - in_ready = (count <= BUF_W-IN_W) && (words_left != 0).
    - An accepted word is appended at bit position count, and words_left is decremented.
    - Extract fires when the registered count >= pix_bits and pix_idx < NUM_PIXELS. It takes the low pix_bits of the buffer and splits them into channels. Each channel byte = min_c + zero-extended residual, mod 256. A skipped channel yields min_c. The byte is written to out_pixels slot pix_idx, then the buffer shifts right by pix_bits and pix_idx increments.
    - Accept and extract can fire in the same cycle: count' = count + IN_W*acc - pix_bits*ext.
    - When the extract for pixel NUM_PIXELS-1 fires, go to OUT and clear the buffer and count (leftover bits are dropped).
  - OUT: out_valid=1 and out_pixels are held stable. On out_ready, go to IDLE.
- in_ready=0 and hdr_ready=0 in every state other than the one named above.
- Reset values:
  - state is IDLE, so hdr_ready reads 1 after reset.
  - out_valid=0, in_ready=0, out_pixels=0.
  - count=0, words_left=0, pix_idx=0.
- Reset mid-block: the block is abandoned and buffered bits are lost; the upstream must resend from the header.

## Timing
- Header handshake in cycle T means DECODE from T+1.
- pix_bits=0: no words are consumed. Extracts fire T+1..T+32 and out_valid rises at T+33.
- pix_bits>0 with in_valid held high: the first word is accepted at T+1 and visible in the buffer at T+2. Extracts fire T+2..T+33 with no stall for any pix_bits <= 32, and out_valid rises at T+34.
- Sustained throughput is one pixel per cycle. A 128-bit buffer with the accept threshold count <= 64 never overflows: count stays <= 128.
- in_valid gaps stall extraction only while count < pix_bits; there are no other stalls.
- Output-to-header: the out_valid&&out_ready cycle is the last OUT cycle, and hdr_ready=1 on the next cycle. Minimum block period is 35 cycles for pix_bits>0.
- If words_left=0 while count < pix_bits, the condition is unreachable with a legal header and the block holds.

## Test plan
- Reset, then idle: hdr_ready=1, out_valid=0, in_ready=0, out_pixels=0.
- All widths 0, hdr_min=0x40302010: no in_ready ever, out_valid at T+33, every pixel = 0x40302010.
- Widths r=g=b=a=8, 16 words of incrementing bytes 0x00..0x7F, min=0x01010101: in_ready high for exactly 16 handshakes, pixel i = bytes[4i..4i+3]+1 per byte, out_valid at T+34.
- Widths {a=0,b=3,g=5,r=2}, min r=0xFE, residual r=3: 10 bits/pixel, 5 words consumed, r wraps to 0x01, a = a_min in all pixels.
- Width field 0xF on r: saturated to 8, so word count and unpack are identical to width 8.
- out_ready held low 10 cycles: out_pixels stable, hdr_ready=0. rst asserted mid-DECODE: next cycle IDLE, out_valid=0, and a fresh header decodes correctly.
